// File: rtl/hiscore_pkg.sv
// ============================================================================
// Module  : hiscore_pkg
// Brief   : Shared state encoding and default geometry for the hiscore bridge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hiscore_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } hs_state_t;

  localparam logic [15:0] c_ram_base = 16'hE000;
  localparam int          c_ram_aw   = 11;
  localparam int          c_timeout  = 4096;

endpackage

`default_nettype wire

// File: rtl/hiscore_ram_bridge.sv
// ============================================================================
// Module  : hiscore_ram_bridge
// Brief   : Halts the game CPU and hands its work RAM to the hiscore engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hiscore_ram_bridge
  import hiscore_pkg::*;
#(
  parameter logic [15:0] RAM_BASE = c_ram_base,
  parameter int          RAM_AW   = c_ram_aw,
  parameter int          TIMEOUT  = c_timeout
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              hs_access,
  input  logic [15:0]       hs_address,
  input  logic [7:0]        hs_data_in,
  input  logic              hs_write,
  output logic [7:0]        hs_data_out,
  output logic              hs_ready,
  output logic              hs_timeout,
  output logic              cpu_pause_req,
  input  logic              cpu_idle,
  input  logic [RAM_AW-1:0] cpu_ram_addr,
  input  logic [7:0]        cpu_ram_din,
  input  logic              cpu_ram_we,
  output logic [7:0]        cpu_ram_dout,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout
);

  localparam int                 c_cnt_w    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  hs_state_t          r_state;
  hs_state_t          w_state_next;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_timeout;
  logic               r_rd_win;
  logic [7:0]         r_data_out;
  logic [15:0]        w_diff;
  logic               w_in_win;
  logic               w_timeout_hit;

  // Wrap-around subtraction makes addresses below the base fall out of window too.
  assign w_diff        = hs_address - RAM_BASE;
  assign w_in_win      = (w_diff >> RAM_AW) == 16'd0;
  assign w_timeout_hit = (r_wait_cnt == c_cnt_last);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (hs_access) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (cpu_idle)           w_state_next = ST_GRANT;
        else if (w_timeout_hit) w_state_next = ST_RELEASE;
        else if (!hs_access)    w_state_next = ST_RELEASE;
      end
      ST_GRANT: begin
        if (!hs_access) w_state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Decoded from state alone so an asynchronous reset frees the RAM at once.
  always_comb begin
    ram_addr      = cpu_ram_addr;
    ram_din       = cpu_ram_din;
    ram_we        = cpu_ram_we;
    cpu_pause_req = 1'b1;
    hs_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cpu_pause_req = 1'b0;
      end
      ST_GRANT: begin
        ram_addr = w_diff[RAM_AW-1:0];
        ram_din  = hs_data_in;
        ram_we   = hs_write & w_in_win;
        hs_ready = 1'b1;
      end
      ST_RELEASE: begin
        ram_we = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
      r_rd_win   <= 1'b0;
      r_data_out <= 8'h00;
    end else begin
      r_wait_cnt <= (r_state == ST_REQ) ? r_wait_cnt + 1'b1 : '0;
      if (r_state == ST_REQ && cpu_idle) begin
        r_timeout <= 1'b0;
      end else if (r_state == ST_REQ && w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
      // Window flag tracks the address through the RAM's one-cycle read latency.
      r_rd_win   <= (r_state == ST_GRANT) && w_in_win;
      r_data_out <= r_rd_win ? ram_dout : 8'h00;
    end
  end

  assign hs_data_out  = r_data_out;
  assign hs_timeout   = r_timeout;
  assign cpu_ram_dout = ram_dout;

endmodule

`default_nettype wire

// File: tb/tb_hiscore_ram_bridge.sv
// ============================================================================
// Module  : tb_hiscore_ram_bridge
// Brief   : Self-checking bench: behavioural bridge model plus directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hiscore_ram_bridge;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        hs_access;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write;
  logic [7:0]  hs_data_out;
  logic        hs_ready;
  logic        hs_timeout;
  logic        cpu_pause_req;
  logic        cpu_idle;
  logic [10:0] cpu_ram_addr;
  logic [7:0]  cpu_ram_din;
  logic        cpu_ram_we;
  logic [7:0]  cpu_ram_dout;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  logic        ram_load;
  logic        mon_en;
  logic        we_seen;
  int          total = 0;
  int          bad   = 0;

  always #5 clk_sys = ~clk_sys;

  hiscore_ram_bridge dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .hs_access     (hs_access),
    .hs_address    (hs_address),
    .hs_data_in    (hs_data_in),
    .hs_write      (hs_write),
    .hs_data_out   (hs_data_out),
    .hs_ready      (hs_ready),
    .hs_timeout    (hs_timeout),
    .cpu_pause_req (cpu_pause_req),
    .cpu_idle      (cpu_idle),
    .cpu_ram_addr  (cpu_ram_addr),
    .cpu_ram_din   (cpu_ram_din),
    .cpu_ram_we    (cpu_ram_we),
    .cpu_ram_dout  (cpu_ram_dout),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_we        (ram_we),
    .ram_dout      (ram_dout)
  );

  // Work RAM: synchronous read-before-write, preloaded with addr ^ 8'h5A.
  logic [7:0] ram [0:2047];
  always @(posedge clk_sys) begin
    if (ram_load) begin
      for (int i = 0; i < 2048; i++) ram[i] <= i[7:0] ^ 8'h5A;
      ram_dout <= 8'h00;
    end else begin
      if (ram_we) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  // Model: phase 0 idle, 1 waiting for CPU halt, 2 owning RAM, 3 handing back.
  int         m_ph   = 0;
  int         m_wait = 0;
  logic       m_tmo  = 1'b0;
  logic [7:0] p1     = 8'h00;
  logic [7:0] p2     = 8'h00;
  logic [7:0] shadow [0:2047];

  always @(negedge clk_sys) begin : cmp
    logic [15:0] diff;
    logic        win;
    logic        e_we;
    logic [10:0] e_addr;
    logic [7:0]  e_din;
    logic [7:0]  e_rd;
    if (ram_load) begin
      for (int i = 0; i < 2048; i++) shadow[i] = i[7:0] ^ 8'h5A;
    end
    if (reset) begin
      m_ph = 0; m_wait = 0; m_tmo = 1'b0; p1 = 8'h00; p2 = 8'h00;
    end
    diff = hs_address - 16'hE000;
    win  = diff < 16'd2048;
    if (m_ph == 2) begin
      e_addr = diff[10:0];
      e_din  = hs_data_in;
      e_we   = hs_write && win;
    end else begin
      e_addr = cpu_ram_addr;
      e_din  = cpu_ram_din;
      e_we   = (m_ph == 3) ? 1'b0 : cpu_ram_we;
    end
    chk("ram_we", {15'd0, ram_we}, {15'd0, e_we});
    chk("ram_addr", {5'd0, ram_addr}, {5'd0, e_addr});
    chk("ram_din", {8'd0, ram_din}, {8'd0, e_din});
    chk("cpu_pause_req", {15'd0, cpu_pause_req}, {15'd0, (m_ph != 0)});
    chk("hs_ready", {15'd0, hs_ready}, {15'd0, (m_ph == 2)});
    chk("hs_timeout", {15'd0, hs_timeout}, {15'd0, m_tmo});
    chk("hs_data_out", {8'd0, hs_data_out}, {8'd0, p2});
    chk("cpu_ram_dout", {8'd0, cpu_ram_dout}, {8'd0, ram_dout});
    if (!reset) begin
      e_rd = (m_ph == 2 && win) ? shadow[diff[10:0]] : 8'h00;
      if (e_we) shadow[e_addr] = e_din;
      p2 = p1;
      p1 = e_rd;
      case (m_ph)
        0: if (hs_access) begin m_ph = 1; m_wait = 0; end
        1: begin
          if (cpu_idle) begin m_ph = 2; m_tmo = 1'b0; end
          else if (m_wait == 4095) begin m_ph = 3; m_tmo = 1'b1; end
          else if (!hs_access) m_ph = 3;
          m_wait++;
        end
        2: if (!hs_access) m_ph = 3;
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk_sys) begin
    if (!mon_en)     we_seen <= 1'b0;
    else if (ram_we) we_seen <= 1'b1;
  end

  initial begin
    int n;
    reset = 1'b1; ram_load = 1'b1; mon_en = 1'b0;
    hs_access = 1'b0; hs_address = 16'h0000; hs_data_in = 8'h00; hs_write = 1'b0;
    cpu_idle = 1'b0; cpu_ram_addr = 11'h000; cpu_ram_din = 8'h00; cpu_ram_we = 1'b0;
    cyc();
    chk("rst_dout", {8'd0, hs_data_out}, 16'h0000);
    chk("rst_pause", {15'd0, cpu_pause_req}, 16'h0000);
    repeat (2) cyc();
    ram_load = 1'b0;
    cyc();
    reset = 1'b0;
    repeat (2) cyc();

    // CPU write passes through while idle
    cpu_ram_addr = 11'h010; cpu_ram_din = 8'h33; cpu_ram_we = 1'b1;
    #1 chk("idle_cpu_we", {15'd0, ram_we}, 16'h0001);
    chk("idle_cpu_addr", {5'd0, ram_addr}, 16'h0010);
    cyc(); cpu_ram_we = 1'b0;

    // Grant after CPU halts three cycles into the request
    hs_access = 1'b1;
    cyc(); chk("req_pause", {15'd0, cpu_pause_req}, 16'h0001);
    cyc(); cyc(); cpu_idle = 1'b1;
    chk("req3_ready", {15'd0, hs_ready}, 16'h0000);
    cyc(); chk("grant_ready_c4", {15'd0, hs_ready}, 16'h0001);

    // In-window write with CPU write strobe ignored, then read-back
    hs_address = 16'hE010; hs_data_in = 8'hA5; hs_write = 1'b1; cpu_ram_we = 1'b1;
    #1 chk("wr_e010_we", {15'd0, ram_we}, 16'h0001);
    chk("wr_e010_addr", {5'd0, ram_addr}, 16'h0010);
    chk("wr_e010_din", {8'd0, ram_din}, 16'h00A5);
    cyc(); hs_write = 1'b0; cpu_ram_we = 1'b0;
    cyc(); cyc(); chk("rd_e010", {8'd0, hs_data_out}, 16'h00A5);
    hs_address = 16'hE020;
    cyc(); cyc(); chk("rd_e020", {8'd0, hs_data_out}, 16'h007A);

    // Out-of-window write dropped, below-base read returns zero
    hs_address = 16'hE800; hs_data_in = 8'hFF; hs_write = 1'b1;
    #1 chk("wr_e800_we", {15'd0, ram_we}, 16'h0000);
    cyc(); hs_write = 1'b0; hs_address = 16'hDFFF;
    cyc(); cyc(); chk("rd_dfff", {8'd0, hs_data_out}, 16'h0000);

    // Top and bottom of the window
    hs_address = 16'hE7FF; hs_data_in = 8'h3C; hs_write = 1'b1;
    #1 chk("wr_e7ff_addr", {5'd0, ram_addr}, 16'h07FF);
    cyc(); hs_write = 1'b0;
    cyc(); cyc(); chk("rd_e7ff", {8'd0, hs_data_out}, 16'h003C);
    hs_address = 16'hE000;
    cyc(); cyc(); chk("rd_e000", {8'd0, hs_data_out}, 16'h005A);

    // Write coincident with hs_access falling still lands
    hs_address = 16'hE030; hs_data_in = 8'hC3; hs_write = 1'b1; hs_access = 1'b0;
    cyc(); hs_write = 1'b0;
    chk("rel_pause", {15'd0, cpu_pause_req}, 16'h0001);
    cyc(); chk("idle_pause", {15'd0, cpu_pause_req}, 16'h0000);

    // Re-request during release goes back through idle
    hs_access = 1'b1;
    cyc(); cyc(); chk("grant2_ready", {15'd0, hs_ready}, 16'h0001);
    hs_access = 1'b0;
    cyc(); hs_access = 1'b1;
    cyc(); chk("rerq_idle_pause", {15'd0, cpu_pause_req}, 16'h0000);
    cyc(); chk("rerq_req_ready", {15'd0, hs_ready}, 16'h0000);
    chk("rerq_req_pause", {15'd0, cpu_pause_req}, 16'h0001);
    cyc(); chk("rerq_grant", {15'd0, hs_ready}, 16'h0001);
    hs_address = 16'hE030;
    cyc(); cyc(); chk("rd_e030", {8'd0, hs_data_out}, 16'h00C3);

    // Asynchronous reset in the middle of a hiscore write
    hs_address = 16'hE040; hs_data_in = 8'h77; hs_write = 1'b1;
    #1 chk("pre_rst_we", {15'd0, ram_we}, 16'h0001);
    reset = 1'b1;
    #1 chk("rst_we", {15'd0, ram_we}, 16'h0000);
    chk("rst_ready", {15'd0, hs_ready}, 16'h0000);
    chk("rst_pause2", {15'd0, cpu_pause_req}, 16'h0000);
    chk("rst_dout2", {8'd0, hs_data_out}, 16'h0000);
    cyc();
    reset = 1'b0; hs_write = 1'b0; hs_access = 1'b0; cpu_idle = 1'b0;
    cpu_ram_addr = 11'h040; cpu_ram_din = 8'h99; cpu_ram_we = 1'b1;
    #1 chk("post_rst_cpu_we", {15'd0, ram_we}, 16'h0001);
    chk("post_rst_cpu_din", {8'd0, ram_din}, 16'h0099);
    cyc(); cpu_ram_we = 1'b0;

    // CPU never halts: bounded wait for the timeout flag
    mon_en = 1'b1; hs_access = 1'b1; n = 0;
    while (hs_timeout !== 1'b1 && n < 5000) begin
      cyc(); n++;
    end
    chk("tmo_cycles", n[15:0], 16'd4097);
    chk("tmo_rel_pause", {15'd0, cpu_pause_req}, 16'h0001);
    hs_access = 1'b0;
    cyc(); chk("tmo_idle_pause", {15'd0, cpu_pause_req}, 16'h0000);
    chk("tmo_sticky", {15'd0, hs_timeout}, 16'h0001);
    chk("tmo_no_we", {15'd0, we_seen}, 16'h0000);
    mon_en = 1'b0;

    // Next grant clears the flag; the CPU byte written after reset is visible
    hs_access = 1'b1; cpu_idle = 1'b1;
    cyc(); chk("tmo_hold_req", {15'd0, hs_timeout}, 16'h0001);
    cyc(); chk("tmo_clear", {15'd0, hs_timeout}, 16'h0000);
    hs_address = 16'hE040;
    cyc(); cyc(); chk("rd_e040", {8'd0, hs_data_out}, 16'h0099);
    hs_access = 1'b0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
